// File: rtl/divider.sv
// Restoring unsigned 32/32 divider producing one quotient bit per clock.
// Result layout is {remainder, quotient} to drop straight into HiLo.
//
// state | meaning
// IDLE  | waiting for Signal==DIVU
// RUN   | 32 restoring iterations, busy high
// DONE  | result valid, waits for Signal to leave DIVU
module divider #(
  parameter logic [5:0] DIVU = 6'd27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        divZero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [5:0]  cnt;

  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // The held remainder is always below the divisor, so only the shifted
  // trial value ever needs the 33rd bit.
  always_comb begin
    rem_sh = {rem, quo[31]};
    trial  = rem_sh - {1'b0, divisor};
    if (trial[32]) begin
      rem_nxt = rem_sh[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end else begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rem     <= 32'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      cnt     <= 6'd0;
      dataOut <= 64'd0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Signal == DIVU) begin
            if (dataB == 32'd0) begin
              dataOut <= {dataA, 32'hFFFF_FFFF};
              divZero <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              quo     <= dataA;
              divisor <= dataB;
              rem     <= 32'd0;
              cnt     <= 6'd0;
              divZero <= 1'b0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            dataOut <= {rem_nxt, quo_nxt};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (Signal != DIVU) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: expected results are queued at start
// and compared when done pulses.
module tb_divider;

  localparam logic [5:0] DIVU = 6'd27;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;
  logic        divZero;

  int vectors = 0;
  int miscompares = 0;
  logic [64:0] exp_q[$];

  divider #(.DIVU(DIVU)) dut (
    .clk(clk),
    .reset(reset),
    .dataA(dataA),
    .dataB(dataB),
    .Signal(Signal),
    .dataOut(dataOut),
    .busy(busy),
    .done(done),
    .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Start one divide, wait for done, compare, optionally hold Signal
  // high afterwards, then drop Signal for one cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    int extra;
    bit ok;
    bit stable;
    logic [63:0] held;
    logic [64:0] e;
    logic [63:0] prod;
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = DIVU;
    held   = dataOut;
    if (b == 32'd0) exp_q.push_back({1'b1, a, 32'hFFFF_FFFF});
    else            exp_q.push_back({1'b0, a % b, a / b});
    n  = 0;
    ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!done) begin
        if (busy !== 1'b1) ok = 1'b0;
        if (dataOut !== held) ok = 1'b0;
        if (divZero !== 1'b0) ok = 1'b0;
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = 6'($urandom_range(0, 63));
      end
    end while (!done && n < 40);
    chk("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    chk("busy_hold", 64'(ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("sb_depth", 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
    chk("dataOut", dataOut, e[63:0]);
    chk("divZero", 64'(divZero), 64'(e[64]));
    if (b != 32'd0) begin
      prod = 64'(dataOut[31:0]) * 64'(b) + 64'(dataOut[63:32]);
      chk("identity", prod, 64'(a));
      chk("rem_lt_div", 64'(dataOut[63:32] < b), 64'd1);
    end
    if (hold > 0) begin
      Signal = DIVU;
      extra  = 0;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (done) extra++;
        if (busy) stable = 1'b0;
        if (dataOut !== e[63:0]) stable = 1'b0;
      end
      chk("hold_extra_done", 64'(extra), 64'd0);
      chk("hold_stable", 64'(stable), 64'd1);
    end
    @(negedge clk);
    Signal = 6'd0;
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    logic [31:0] a;
    logic [31:0] b;
    dataA  = 32'd0;
    dataB  = 32'd0;
    Signal = 6'd0;
    reset  = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_dataOut", dataOut, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_divZero", 64'(divZero), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    do_div(32'd100, 32'd7, 0);
    do_div(32'hFFFF_FFFF, 32'd1, 0);
    do_div(32'd3, 32'd10, 0);
    do_div(32'd5, 32'd0, 0);
    do_div(32'd100, 32'd7, 0);

    // Reset in the middle of an iteration run.
    @(negedge clk);
    dataA  = 32'd100;
    dataB  = 32'd7;
    Signal = DIVU;
    repeat (11) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_dataOut", dataOut, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_divZero", 64'(divZero), 64'd0);
    Signal = 6'd0;
    dones = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    do_div(32'd9, 32'd3, 0);

    do_div(32'd100, 32'd7, 40);
    do_div(32'd50, 32'd7, 0);
    do_div(32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_div(32'd12345, 32'd0, 0);
    do_div(32'h7FFF_FFFF, 32'h8000_0000, 0);

    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1001, 32'hFFFF_FFFF);
        end
        1: begin
          a = $urandom;
          b = 32'h8000_0000;
        end
        2: begin
          a = $urandom;
          b = $urandom;
          if (b == 32'd0) b = 32'd1;
        end
        default: begin
          a = $urandom;
          b = $urandom_range(1, 255);
        end
      endcase
      do_div(a, b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter DIVU, default 6'd27, the Signal code that requests an unsigned divide.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port dataA, input, 32, the unsigned dividend.
REQ-005 The block SHALL have port dataB, input, 32, the unsigned divisor.
REQ-006 The block SHALL have port Signal, input, 6, the operation code from ALUControl.
REQ-007 The block SHALL have port dataOut, output, 64, the result {remainder[63:32], quotient[31:0]}, matching the HiLo Hi/Lo layout.
REQ-008 The block SHALL have port busy, output, 1, high while a divide is iterating.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse when dataOut becomes valid.
REQ-010 The block SHALL have port divZero, output, 1, high when the last completed divide had divisor 0.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-012 In IDLE with Signal==DIVU and dataB!=0, the block SHALL load the dividend into the quotient register, the divisor into the divisor register, clear the 33-bit partial remainder and the 6-bit counter, and go to RUN.
REQ-013 In IDLE with Signal==DIVU and dataB==0, the block SHALL go to DONE at the next edge, with quotient=32'hFFFFFFFF, remainder=dataA, divZero=1 and done=1 (latency 1).
REQ-014 Each RUN cycle SHALL perform one restoring step: shift {rem,quo} left 1; trial = rem - {1'b0,divisor} (33 bits); if trial is non-negative, rem=trial and quo[0]=1, else rem unchanged and quo[0]=0.
REQ-015 RUN SHALL last exactly 32 cycles; the block SHALL enter DONE on the 32nd iteration edge, so done rises 33 edges after the start edge.
REQ-016 busy SHALL be 1 exactly in RUN, and done SHALL be 1 only for the first cycle in DONE.
REQ-017 dataOut SHALL update only on completion and SHALL hold its value through DONE, IDLE and the next RUN, until the next completion.
REQ-018 divZero SHALL be cleared on every start and set only per REQ-013.
REQ-019 Changes on dataA, dataB and Signal during RUN SHALL be ignored; no abort exists.
REQ-020 DONE SHALL return to IDLE only when Signal!=DIVU, so a held Signal==DIVU never restarts the divide.
REQ-021 Arithmetic SHALL be unsigned only; for divisor!=0 the result SHALL satisfy quotient*divisor+remainder==dividend with remainder<divisor.

Reset
REQ-022 Asserting reset low SHALL immediately, without a clock, force IDLE, dataOut=64'd0, busy=0, done=0, divZero=0, and clear the counter and internal registers.
REQ-023 A reset mid-RUN SHALL abandon the operation with no done pulse, and a new start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-024 dataA=100, dataB=7, Signal=27 -> busy for 32 cycles, then done pulse, dataOut={32'd2, 32'd14}, divZero=0.
REQ-025 dataA=32'hFFFFFFFF, dataB=1 -> after 33 edges, dataOut={32'd0, 32'hFFFFFFFF}; dataA=3, dataB=10 -> dataOut={32'd3, 32'd0}.
REQ-026 dataA=5, dataB=0 -> one edge later done=1, divZero=1, dataOut={32'd5, 32'hFFFFFFFF}, busy never high.
REQ-027 Start 100/7, pull reset low at iteration 10 -> all outputs 0 at once, no done pulse; release reset, start 9/3 -> dataOut={32'd0, 32'd3} after 33 edges.
REQ-028 Signal held at 27 for 40 cycles after done -> exactly one done pulse and dataOut stable; drop Signal to 0 for one cycle then 27 with dataB=7 (new operands) -> a second divide runs.
REQ-029 Random dataA and nonzero dataB (at least 1000 cases, including dataB > dataA and dataB = 32'h80000000) -> the REQ-021 identity holds and the latency is exactly 33 edges.
